// File: rtl/cpu_controller.sv
// cpu_controller -- eight-phase instruction sequencer for a simple accumulator CPU.
//
// Each instruction takes eight phases (INST_ADDR..STORE), one per clock.
// The sequence holds in INST_FETCH until an instruction word is offered.
// It also holds in OP_ADDR while a HLT instruction is parked, until resume.
// Datapath strobes are pure decodes of the registered phase, the IR and zero.
//
// Ports
//   clk, rst_      clock; asynchronous active-low reset
//   instr_valid    instr_data carries a valid instruction word
//   instr_data     [7:5] opcode, [4:0] operand address
//   zero           accumulator-is-zero flag (only looked at in ALU_OP)
//   resume         single-cycle pulse releasing a parked HLT
//   instr_ready    controller accepts instr_data this cycle (INST_FETCH)
//   opcode         IR[7:5] to the ALU
//   sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr   datapath strobes
//   phase          current phase number (debug)
module cpu_controller (
   input  logic       clk,
   input  logic       rst_,
   input  logic       instr_valid,
   input  logic [7:0] instr_data,
   input  logic       zero,
   input  logic       resume,
   output logic       instr_ready,
   output logic [2:0] opcode,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       halt,
   output logic       ld_pc,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr,
   output logic [2:0] phase
);
   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   phase_t     state, state_nxt;
   logic [7:0] ir;
   logic       halted, halted_nxt;
   logic       is_hlt, is_aluop;

   assign opcode      = ir[7:5];
   assign is_hlt      = (opcode == OP_HLT);
   assign is_aluop    = (opcode == OP_ADD) || (opcode == OP_AND) ||
                        (opcode == OP_XOR) || (opcode == OP_LDA);
   assign instr_ready = (state == INST_FETCH);
   assign phase       = state;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state  <= INST_ADDR;
         ir     <= 8'h00;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         halted <= halted_nxt;
         if (instr_valid && instr_ready)
            ir <= instr_data;
      end
   end

   always_comb begin
      state_nxt  = phase_t'(state + 3'd1);  // natural wrap 7 -> 0
      halted_nxt = halted;
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      case (state)
         INST_ADDR: sel = 1'b1;
         INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
            if (!instr_valid)
               state_nxt = INST_FETCH;
         end
         INST_LOAD: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
            // IR is stable here, so arm the halt flag on entry to OP_ADDR;
            // that lets a resume in the very first OP_ADDR cycle count.
            halted_nxt = is_hlt;
         end
         OP_ADDR: begin
            halt   = is_hlt;
            inc_pc = !is_hlt;
            if (halted) begin
               if (resume) halted_nxt = 1'b0;
               else        state_nxt  = OP_ADDR;
            end
         end
         OP_FETCH: rd = is_aluop;
         ALU_OP: begin
            rd     = is_aluop;
            inc_pc = (opcode == OP_SKZ) && zero;
            ld_pc  = (opcode == OP_JMP);
            data_e = (opcode == OP_STO);
         end
         STORE: begin
            rd     = is_aluop;
            ld_pc  = (opcode == OP_JMP);
            data_e = (opcode == OP_STO);
            ld_ac  = is_aluop;
            wr     = (opcode == OP_STO);
         end
      endcase
   end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller -- directed and randomized checks of cpu_controller
// against a phase-counter reference model built from the instruction rules.
module tb_cpu_controller;
   logic       clk = 1'b0;
   logic       rst_;
   logic       instr_valid;
   logic [7:0] instr_data;
   logic       zero;
   logic       resume;
   logic       instr_ready;
   logic [2:0] opcode;
   logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
   logic [2:0] phase;

   int n_checks = 0;
   int n_err    = 0;

   // reference model state
   int         m_phase = 0;
   logic [7:0] m_ir    = 8'h00;

   always #5 clk = ~clk;

   cpu_controller dut (
      .clk(clk), .rst_(rst_), .instr_valid(instr_valid), .instr_data(instr_data),
      .zero(zero), .resume(resume), .instr_ready(instr_ready), .opcode(opcode),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
      .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .phase(phase)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs straight from the per-phase strobe table.
   task automatic check_outs();
      logic [2:0] op;
      logic       alu;
      logic [8:0] e;
      int         p;
      p   = m_phase;
      op  = m_ir[7:5];
      alu = (op >= 3'd2) && (op <= 3'd5);
      e[8] = (p <= 3);                                   // sel
      e[7] = (p >= 1 && p <= 3) || (p >= 5 && alu);      // rd
      e[6] = (p == 2 || p == 3);                         // ld_ir
      e[5] = (p == 4 && op != 3'd0) || (p == 6 && op == 3'd1 && zero); // inc_pc
      e[4] = (p == 4 && op == 3'd0);                     // halt
      e[3] = (p >= 6 && op == 3'd7);                     // ld_pc
      e[2] = (p >= 6 && op == 3'd6);                     // data_e
      e[1] = (p == 7 && alu);                            // ld_ac
      e[0] = (p == 7 && op == 3'd6);                     // wr
      chk("phase", {29'd0, phase}, p);
      chk("instr_ready", {31'd0, instr_ready}, (p == 1) ? 1 : 0);
      chk("opcode", {29'd0, opcode}, {29'd0, op});
      chk("ir", {24'd0, dut.ir}, {24'd0, m_ir});
      chk("strobes", {23'd0, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}, {23'd0, e});
   endtask

   // One clock: drive inputs in the low half, check, take the edge, advance model.
   task automatic tick(input logic v, input logic [7:0] d, input logic z, input logic r);
      instr_valid = v;
      instr_data  = d;
      zero        = z;
      resume      = r;
      #1;
      check_outs();
      @(posedge clk);
      if (!rst_) begin
         m_phase = 0;
         m_ir    = 8'h00;
      end else if (m_phase == 1) begin
         if (v) begin
            m_ir    = d;
            m_phase = 2;
         end
      end else if (m_phase == 4 && m_ir[7:5] == 3'd0) begin
         if (r) m_phase = 5;                 // parked HLT leaves only on resume
      end else begin
         m_phase = (m_phase + 1) % 8;
      end
      @(negedge clk);
   endtask

   task automatic async_reset();
      rst_ = 1'b0;
      #1;
      m_phase = 0;
      m_ir    = 8'h00;
      check_outs();
   endtask

   // Advance to a target phase with benign inputs; a missed bound is a failure.
   task automatic goto_phase(input int p, input logic z);
      int n = 0;
      while (m_phase != p && n < 30) begin
         tick(1'b1, 8'h45, z, 1'b1);
         n++;
      end
      chk("goto_phase_bound", {29'd0, phase}, p);
   endtask

   // Run the fetched instruction from its INST_LOAD phase back to INST_ADDR.
   task automatic finish_instr(input logic z);
      int n = 0;
      while (m_phase != 0 && n < 30) begin
         tick(1'b0, $urandom, z, 1'b0);
         n++;
      end
      chk("finish_bound", {29'd0, phase}, 0);
   endtask

   initial begin
      logic [7:0] prog [8];
      int         cnt;
      prog = '{8'h00, 8'h3F, 8'h4A, 8'h63, 8'h8C, 8'hA5, 8'hC6, 8'hE7};

      // reset state, held across edges
      rst_ = 1'b0; instr_valid = 1'b0; instr_data = 8'h00; zero = 1'b0; resume = 1'b0;
      @(negedge clk);
      tick(1'b1, 8'hFF, 1'b1, 1'b1);
      tick(1'b1, 8'hFF, 1'b1, 1'b1);
      rst_ = 1'b1;
      tick(1'b0, 8'h00, 1'b0, 1'b0);            // first edge after reset -> phase 1

      // fetch handshake: three stall cycles then ADD 5
      repeat (3) tick(1'b0, 8'h99, 1'b0, 1'b0);
      tick(1'b1, 8'h45, 1'b0, 1'b0);
      chk("ir_after_accept", {24'd0, dut.ir}, 32'h45);
      finish_instr(1'b1);

      // SKZ with zero=1 then zero=0
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 8'h20, 1'b1, 1'b0);
      finish_instr(1'b1);
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 8'h20, 1'b0, 1'b0);
      finish_instr(1'b0);

      // HLT: resume in phase 2 ignored, park 5 cycles, then resume
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 8'h00, 1'b0, 1'b0);
      tick(1'b0, 8'h00, 1'b0, 1'b1);            // phase 2, resume ignored
      tick(1'b0, 8'h00, 1'b0, 1'b0);            // phase 3
      repeat (5) tick(1'b0, 8'h00, 1'b0, 1'b0); // parked in phase 4
      chk("hlt_parked", {29'd0, phase}, 4);
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      chk("hlt_resumed", {29'd0, phase}, 5);
      finish_instr(1'b0);

      // STO and JMP
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 8'hC3, 1'b0, 1'b0);
      finish_instr(1'b0);
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 8'hE7, 1'b0, 1'b0);
      finish_instr(1'b1);

      // reset in phase 6 of STO
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 8'hC3, 1'b0, 1'b0);
      goto_phase(6, 1'b0);
      async_reset();
      chk("rst_sel", {31'd0, sel}, 1);
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      rst_ = 1'b1;
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_rst_phase", {29'd0, phase}, 1);

      // back-to-back, every opcode, instr_valid held high
      goto_phase(0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cnt = 0;
         do begin
            tick(1'b1, (m_phase == 1) ? prog[i] : 8'($urandom), 1'($urandom), 1'b1);
            cnt++;
         end while (phase != 3'd0 && cnt < 20);
         chk("latency", cnt, 8);
      end

      // randomized run with occasional async resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            async_reset();
            tick(1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
            rst_ = 1'b1;
         end
         tick(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom),
              ($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
